// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared loader state, geometry derivations and scissor test
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } loaderState_t;

    function automatic int pixelPerBeat(input int streamWidth, input int pixelWidth);
        return streamWidth / pixelWidth;
    endfunction

    function automatic int strobesPerBeat(input int streamWidth, input int subPixelWidth);
        return streamWidth / subPixelWidth;
    endfunction

    function automatic int frameSizeInBeats(input int xResolution, input int yLineResolution, input int pixPerBeat);
        return xResolution * yLineResolution / pixPerBeat;
    endfunction

    // Start coordinates are inclusive, end coordinates exclusive.
    function automatic logic scissorTest(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] startX,
        input logic [31:0] startY,
        input logic [31:0] endX,
        input logic [31:0] endY
    );
        return (x >= startX) && (x < endX) && (y >= startY) && (y < endY);
    endfunction

endpackage

// File: rtl/frame_buffer_scissor_mask.sv
// frame_buffer_scissor_mask: per-sub-pixel write strobes for one beat from the scissor window
//   enable                      scissor enable; when low every strobe is set
//   x, y                        screen position of pixel 0 of the beat
//   startX/startY/endX/endY     scissor window, start inclusive, end exclusive
//   mask                        NUMBER_OF_SUB_PIXELS strobes per pixel, pixel 0 in the LSBs
module frame_buffer_scissor_mask
    import frame_buffer_pkg::*;
#(
    parameter int NUMBER_OF_SUB_PIXELS = 4,
    parameter int PIXEL_PER_BEAT = 1,
    parameter int SCREEN_POS_WIDTH = 16
) (
    input  logic                                            enable,
    input  logic [SCREEN_POS_WIDTH-1:0]                     x,
    input  logic [SCREEN_POS_WIDTH-1:0]                     y,
    input  logic [SCREEN_POS_WIDTH-1:0]                     startX,
    input  logic [SCREEN_POS_WIDTH-1:0]                     startY,
    input  logic [SCREEN_POS_WIDTH-1:0]                     endX,
    input  logic [SCREEN_POS_WIDTH-1:0]                     endY,
    output logic [PIXEL_PER_BEAT*NUMBER_OF_SUB_PIXELS-1:0]  mask
);

    for (genvar p = 0; p < PIXEL_PER_BEAT; p++) begin : gPixel
        logic [SCREEN_POS_WIDTH-1:0] px;
        assign px = x + SCREEN_POS_WIDTH'(p);
        assign mask[p*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] =
            {NUMBER_OF_SUB_PIXELS{!enable || scissorTest(32'(px), 32'(y), 32'(startX), 32'(startY), 32'(endX), 32'(endY))}};
    end

endmodule

// File: rtl/frame_buffer_stream_loader.sv
// frame_buffer_stream_loader: AXIS slave that reloads a framebuffer tile into the tile RAM write port
//   clk, reset                  clock, synchronous active-high reset
//   apply/applied/cmdLoad       command handshake; applied is high while idle
//   confYOffset                 y of the tile's first line (scissor build only)
//   confEnableScissor, confScissor*  scissor window (scissor build only)
//   s_axis_*                    input stream, beats in RAM address order, pixel 0 in the LSBs
//   memWrite*                   RAM write port, one cycle after each accepted beat
//   loadError                   sticky framing error, cleared by the next load command
// Optional feature macro: LOADER_SCISSOR_EN (per-pixel scissor masking of the writes).
module frame_buffer_stream_loader
    import frame_buffer_pkg::*;
#(
    parameter int STREAM_WIDTH = 16,
    parameter int NUMBER_OF_SUB_PIXELS = 4,
    parameter int SUB_PIXEL_WIDTH = 4,
    parameter int X_RESOLUTION = 1024,
    parameter int Y_LINE_RESOLUTION = 48,
    parameter int SCREEN_POS_WIDTH = 16,
    localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int PIXEL_PER_BEAT = pixelPerBeat(STREAM_WIDTH, PIXEL_WIDTH),
    localparam int STROBES_PER_BEAT = strobesPerBeat(STREAM_WIDTH, SUB_PIXEL_WIDTH),
    localparam int FRAME_SIZE_IN_BEATS = frameSizeInBeats(X_RESOLUTION, Y_LINE_RESOLUTION, PIXEL_PER_BEAT),
    localparam int MEM_ADDR_WIDTH = $clog2(FRAME_SIZE_IN_BEATS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        apply,
    output logic                        applied,
    input  logic                        cmdLoad,
    input  logic [11:0]                 confYOffset,
    input  logic                        confEnableScissor,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorStartX,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorStartY,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorEndX,
    input  logic [SCREEN_POS_WIDTH-1:0] confScissorEndY,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]     s_axis_tdata,
    output logic                        memWrite,
    output logic [MEM_ADDR_WIDTH-1:0]   memWriteAddr,
    output logic [STREAM_WIDTH-1:0]     memWriteData,
    output logic [STROBES_PER_BEAT-1:0] memWriteMask,
    output logic                        loadError
);

    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_INDEX = MEM_ADDR_WIDTH'(FRAME_SIZE_IN_BEATS - 1);

    loaderState_t state, nextState;
    logic [MEM_ADDR_WIDTH-1:0] index;
    logic [STROBES_PER_BEAT-1:0] beatMask;
    logic handshake, loadBeat, isLastBeat;

    assign handshake = s_axis_tvalid && s_axis_tready;
    assign loadBeat = handshake && state == LOAD;
    assign isLastBeat = index == LAST_INDEX;

    // tlast always ends the frame; a full frame without tlast drains the remainder.
    always_comb begin
        nextState = state;
        if (state == IDLE && apply && cmdLoad) nextState = LOAD;
        if (handshake && state != IDLE)
            nextState = s_axis_tlast ? IDLE : (state == LOAD && isLastBeat) ? DRAIN : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            applied <= 1'b1;
            s_axis_tready <= 1'b0;
            memWrite <= 1'b0;
            memWriteAddr <= '0;
            memWriteData <= '0;
            memWriteMask <= '0;
            loadError <= 1'b0;
            index <= '0;
        end else begin
            state <= nextState;
            s_axis_tready <= nextState != IDLE;
            applied <= state == IDLE && !(apply && cmdLoad);
            memWrite <= loadBeat;
            if (loadBeat) begin
                memWriteAddr <= index;
                memWriteData <= s_axis_tdata;
                memWriteMask <= beatMask;
            end
            index <= state == IDLE ? '0 : loadBeat ? index + MEM_ADDR_WIDTH'(1) : index;
            if (state == IDLE && apply && cmdLoad) loadError <= 1'b0;
            else if (loadBeat && (s_axis_tlast != isLastBeat)) loadError <= 1'b1;
        end
    end

`ifdef LOADER_SCISSOR_EN
    logic [SCREEN_POS_WIDTH-1:0] x, y;
    logic lineEnd;

    assign lineEnd = x + SCREEN_POS_WIDTH'(PIXEL_PER_BEAT) == SCREEN_POS_WIDTH'(X_RESOLUTION);

    // Lines are stored top-down, so y counts down from the tile's last line.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            x <= '0;
            y <= SCREEN_POS_WIDTH'(confYOffset) + SCREEN_POS_WIDTH'(Y_LINE_RESOLUTION - 1);
        end else if (loadBeat) begin
            x <= lineEnd ? '0 : x + SCREEN_POS_WIDTH'(PIXEL_PER_BEAT);
            y <= lineEnd ? y - SCREEN_POS_WIDTH'(1) : y;
        end
    end

    frame_buffer_scissor_mask #(
        .NUMBER_OF_SUB_PIXELS(NUMBER_OF_SUB_PIXELS),
        .PIXEL_PER_BEAT(PIXEL_PER_BEAT),
        .SCREEN_POS_WIDTH(SCREEN_POS_WIDTH)
    ) scissorMask (
        .enable(confEnableScissor),
        .x(x),
        .y(y),
        .startX(confScissorStartX),
        .startY(confScissorStartY),
        .endX(confScissorEndX),
        .endY(confScissorEndY),
        .mask(beatMask)
    );
`else
    logic unusedScissorPorts;

    assign beatMask = '1;
    assign unusedScissorPorts = ^{confYOffset, confEnableScissor, confScissorStartX,
                                  confScissorStartY, confScissorEndX, confScissorEndY};
`endif

endmodule

// File: doc/frame_buffer_stream_loader.md
Name: frame_buffer_stream_loader

Overview:
AXIS slave that reloads a framebuffer tile from a stream. It is the inverse of the framebuffer commit path: beats arrive in commit order (address 0 upward) and are written into the tile RAM through its write port. It sits between a DMA/memory reader and the framebuffer's DualPortRam write port, under the same apply/applied command handshake the rasterizer control already uses.

Parameters:
STREAM_WIDTH, 16, AXIS data width and RAM word width in bits.
NUMBER_OF_SUB_PIXELS, 4, channels per pixel.
SUB_PIXEL_WIDTH, 4, bits per channel; also the RAM write strobe granularity.
X_RESOLUTION, 1024, pixels per line.
Y_LINE_RESOLUTION, 48, lines per tile.
SCREEN_POS_WIDTH, 16, width of scissor/offset coordinates.
Derived (localparam):
- PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH
- PIXEL_PER_BEAT = STREAM_WIDTH/PIXEL_WIDTH
- STROBES_PER_BEAT = STREAM_WIDTH/SUB_PIXEL_WIDTH
- FRAME_SIZE_IN_BEATS (N) = X_RESOLUTION*Y_LINE_RESOLUTION/PIXEL_PER_BEAT
- MEM_ADDR_WIDTH = clog2(N)

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
apply  in  1  start command; sampled only in IDLE.
applied  out  1  1 = idle/finished; 0 = load in progress.
cmdLoad  in  1  load command; apply without cmdLoad is a no-op (applied stays 1).
confYOffset  in  12  y of the tile's first line (scissor only).
confEnableScissor  in  1  scissor enable (scissor feature only).
confScissorStartX/StartY/EndX/EndY  in  SCREEN_POS_WIDTH each  scissor window; start inclusive, end exclusive.
s_axis_tvalid  in  1  AXIS valid.
s_axis_tready  out  1  AXIS ready.
s_axis_tlast  in  1  last beat of a frame.
s_axis_tdata  in  STREAM_WIDTH  pixel data; pixel 0 in the LSBs.
memWrite  out  1  RAM write enable.
memWriteAddr  out  MEM_ADDR_WIDTH  RAM word address.
memWriteData  out  STREAM_WIDTH  RAM write data.
memWriteMask  out  STROBES_PER_BEAT  per-sub-pixel write strobes.
loadError  out  1  sticky framing error flag.

Behaviour:
- Reset:
  - state = IDLE; applied = 1; s_axis_tready = 0; memWrite = 0; memWriteMask = 0; loadError = 0; beat index = 0.
  - Reset during LOAD or DRAIN aborts immediately. No further write is issued, including one already registered but not yet emitted.
- States: IDLE, LOAD, DRAIN. s_axis_tready = (state == LOAD || state == DRAIN), driven from a register. No combinational path from tvalid to tready.
- IDLE:
  - index = 0; x = 0; y = confYOffset + Y_LINE_RESOLUTION - 1.
  - apply && cmdLoad: next cycle applied = 0, loadError = 0, state = LOAD.
  - apply && !cmdLoad: applied stays 1.
- LOAD, per accepted beat (tvalid && tready):
  - Next cycle: memWrite = 1, memWriteAddr = index, memWriteData = tdata, memWriteMask = all ones (AND scissor mask when the feature is compiled in). Write latency is exactly 1 cycle after the handshake.
  - memWrite = 0 on any cycle without a handshake the cycle before.
  - index += 1; x += PIXEL_PER_BEAT. When x + PIXEL_PER_BEAT == X_RESOLUTION: x = 0, y -= 1.
- LOAD termination:
  - index == N-1 && tlast: normal end. State = IDLE; applied = 1 one cycle after the final write is emitted.
  - index == N-1 && !tlast: beat is written. loadError = 1; state = DRAIN.
  - index < N-1 && tlast: early end. Beat is written; loadError = 1; state = IDLE. Remaining RAM words are untouched.
- DRAIN: accept and discard beats (no writes) until a beat with tlast, then go to IDLE.
- Arithmetic: index, x and y are unsigned and wrap modulo 2^width. y is compared against the scissor window as SCREEN_POS_WIDTH unsigned.
- apply while not in IDLE is ignored.

Optional Feature:
LOADER_SCISSOR_EN
- Defined: pixel p of a beat is written only if !confEnableScissor, or (x+p in [StartX, EndX) and y in [StartY, EndY)). Each pixel's NUMBER_OF_SUB_PIXELS strobes follow that pixel's test.
- Undefined: scissor ports are present but ignored; memWriteMask is all ones for every write, and x/y tracking is removed.

Decomposition:
- Package frame_buffer_pkg: loader state enum, PIXEL_PER_BEAT / STROBES_PER_BEAT / FRAME_SIZE_IN_BEATS derivation functions, and the shared scissor test function (same semantics as the framebuffer memset scissor).
- One sub-module, frame_buffer_scissor_mask: combinational (x, y, window) -> STROBES_PER_BEAT mask. Instantiated only under LOADER_SCISSOR_EN.

Test Plan:
All tests use STREAM_WIDTH=32, PIXEL_WIDTH=16, X_RESOLUTION=8, Y_LINE_RESOLUTION=2, giving PIXEL_PER_BEAT=2 and N=8.
1. apply+cmdLoad, 8 beats with tdata=0x00010000*k+k and tlast on beat 7 → writes at addr 0..7 carry matching data and mask 0xFF, each 1 cycle after its handshake; applied=1; loadError=0.
2. Random tvalid gaps and backpressure-free run → no write on idle cycles, write order preserved, total writes = 8.
3. tlast on beat 3 → addrs 0..3 written, 4..7 untouched, loadError=1, return to IDLE; next apply clears loadError.
4. 10 beats with tlast only on beat 9 → addrs 0..7 written, beats 8..9 accepted without writes, loadError=1.
5. LOADER_SCISSOR_EN, enable=1, window X[1,5) Y[0,1), confYOffset=0 → beats at y=1 get mask 0x00; beats 4..7 (y=0) get masks 0xF0, 0xFF, 0x0F, 0x00.
6. reset asserted after beat 4 → memWrite=0 from the next cycle, tready=0, applied=1, index 0; a fresh load then writes addr 0 first.
